// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch front end: bus widths, reset PC,
// the NOP encoding presented when no instruction is available, and the fetch FSM
// state type.
package inst_fetch_buffer_pkg;

  localparam int          REG_BUS      = 64;
  localparam int          INST_BUS     = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} entries.
// Ports:
//   clk, rst          clock, async active-high reset
//   push_i, data_i    write an entry (accepted when not full, or full with pop_i)
//   pop_i             drop the head entry (ignored when empty)
//   flush_i           empty the FIFO; wins over push/pop in the same cycle
//   data_o            head entry (undefined content when empty_o)
//   full_o, empty_o   occupancy flags
//   count_o           number of valid entries, 0..DEPTH
module inst_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + AW'(do_push);
      rd_d  = rd_q + AW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction-fetch front end. Issues sequential in-order fetches on a
// req/gnt/rvalid memory port, buffers returned words with their PCs, and hands
// them to decode over a valid/ready handshake. A redirect flushes the buffer and
// discards every response still in flight.
// Ports:
//   clk, rst                       clock, async active-high reset
//   redirect_valid, redirect_pc    restart fetch at redirect_pc
//   mem_req, mem_addr, mem_gnt     request channel (addr stable while stalled)
//   mem_rvalid, mem_rdata          in-order response channel
//   inst_valid, inst, inst_pc      buffer head (NOP / RESET_PC when empty)
//   inst_ready                     decode pops the head
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int                ADDR_W   = REG_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic              redir_q;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [CW:0]       credit_used;
  logic              gnt_fire, resp_ok, drop, push, pop;

  // Every in-flight request owns a FIFO slot, so a response always has room.
  assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
  // The cycle after a redirect never requests: the new PC settles first.
  assign mem_req  = (state_q == ST_RUN) && !redir_q && (credit_used < (CW+1)'(DEPTH));
  assign mem_addr = pc_q;
  assign gnt_fire = mem_req && mem_gnt;

  // Responses with nothing outstanding are a protocol error and are ignored.
  assign resp_ok  = mem_rvalid && (outst_q != '0);
  assign drop     = resp_ok && (discard_q != '0);
  assign push     = resp_ok && (discard_q == '0);
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? fifo_head[EW-1 -: INST_W] : INST_W'(NOP_INST);
  assign inst_pc    = inst_valid ? fifo_head[ADDR_W-1:0] : RESET_PC;

  always_comb begin
    outst_d   = outst_q + CW'(gnt_fire) - CW'(resp_ok);
    // Everything still in flight after a redirect belongs to the old stream.
    discard_d = redirect_valid ? outst_d : (discard_q - CW'(drop));

    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (gnt_fire)   pc_d = pc_q + ADDR_W'(4);

    resp_pc_d = resp_pc_q;
    if (redirect_valid)  resp_pc_d = redirect_pc;
    else if (push)       resp_pc_d = resp_pc_q + ADDR_W'(4);

    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (redirect_valid && (outst_d != '0)) state_d = ST_FLUSH;
      ST_FLUSH: if (redirect_valid)          state_d = ST_FLUSH;
                else if (discard_d == '0)    state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      outst_q   <= '0;
      discard_q <= '0;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      redir_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      redir_q   <= redirect_valid;
    end
  end

  inst_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({mem_rdata, resp_pc_q}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && (outst_q == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && fifo_full && !redirect_valid) |-> pop);

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.ADDR_W(64), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: requests in flight (with a "belongs to old stream" flag),
  // buffered PCs, next expected fetch address.
  logic [63:0] infl_addr [$];
  bit          infl_stale[$];
  logic [63:0] fifo_pc   [$];
  logic [63:0] exp_addr;
  int          stale_cnt;
  bit          boot, prev_redir;
  int          n_grants;

  function automatic logic [31:0] fdata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // One clock of stimulus; called and returns at a negedge. Compares every DUT
  // output against the model before driving the next inputs.
  task automatic step(input bit g, input bit rv, input bit rdy, input bit redir,
                      input logic [63:0] rpc);
    bit exp_req, exp_v, rvv;
    logic [63:0] hpc;
    exp_req = !boot && !prev_redir && (stale_cnt == 0) &&
              (infl_addr.size() + fifo_pc.size() < DEPTH);
    exp_v   = fifo_pc.size() != 0;
    hpc     = exp_v ? fifo_pc[0] : RPC;
    n_checks++;
    if (mem_req !== exp_req) begin
      n_fail++; $display("FAIL mem_req t=%0t got %b want %b", $time, mem_req, exp_req);
    end
    n_checks++;
    if (mem_addr !== exp_addr) begin
      n_fail++; $display("FAIL mem_addr t=%0t got %h want %h", $time, mem_addr, exp_addr);
    end
    n_checks++;
    if (inst_valid !== exp_v) begin
      n_fail++; $display("FAIL inst_valid t=%0t got %b want %b", $time, inst_valid, exp_v);
    end
    n_checks++;
    if (inst_pc !== hpc) begin
      n_fail++; $display("FAIL inst_pc t=%0t got %h want %h", $time, inst_pc, hpc);
    end
    n_checks++;
    if (inst !== (exp_v ? fdata(hpc) : NOP)) begin
      n_fail++; $display("FAIL inst t=%0t got %h want %h", $time, inst, exp_v ? fdata(hpc) : NOP);
    end

    rvv            = rv && (infl_addr.size() != 0);
    mem_gnt        = g;
    mem_rvalid     = rvv;
    mem_rdata      = rvv ? fdata(infl_addr[0]) : $urandom();
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;

    if (exp_v && rdy && !redir) void'(fifo_pc.pop_front());
    if (rvv) begin
      logic [63:0] a;
      bit s;
      a = infl_addr.pop_front();
      s = infl_stale.pop_front();
      if (s) stale_cnt--;
      else   fifo_pc.push_back(a);
    end
    if (exp_req && g) begin
      infl_addr.push_back(exp_addr);
      infl_stale.push_back(1'b0);
      exp_addr += 64'd4;
      n_grants++;
    end
    if (redir) begin
      foreach (infl_stale[i]) infl_stale[i] = 1'b1;
      stale_cnt = infl_addr.size();
      fifo_pc.delete();
      exp_addr = rpc;
    end
    prev_redir = redir;
    boot       = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_gnt = 0; mem_rvalid = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
    infl_addr.delete(); infl_stale.delete(); fifo_pc.delete();
    stale_cnt = 0; n_grants = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0; boot = 1'b1; prev_redir = 1'b0; exp_addr = RPC;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got req=%b v=%b want 0 0", mem_req, inst_valid);
    end
    n_checks++;
    if (mem_addr !== RPC || inst_pc !== RPC || inst !== NOP) begin
      n_fail++; $display("FAIL reset_values got addr=%h pc=%h inst=%h", mem_addr, inst_pc, inst);
    end
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    repeat (3) step(1, 1, 1, 0, '0);   // boot, grant, rvalid
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RPC) begin
      n_fail++; $display("FAIL first_word got v=%b pc=%h want 1 %h", inst_valid, inst_pc, RPC);
    end
    repeat (20) step(1, 1, 1, 0, '0);
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (12) step(1, 1, 0, 0, '0);
    n_checks++;
    if (n_grants != DEPTH || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL credit_stop got grants=%0d req=%b want %0d 0", n_grants, mem_req, DEPTH);
    end
    step(1, 1, 1, 0, '0);               // single pop
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL credit_return got req=%b want 1", mem_req);
    end
    repeat (4) step(1, 1, 0, 0, '0);
    n_checks++;
    if (n_grants != DEPTH + 1) begin
      n_fail++; $display("FAIL credit_one got grants=%0d want %0d", n_grants, DEPTH + 1);
    end
    repeat (8) step(1, 1, 1, 0, '0);
  endtask

  task automatic test_redirect();
    apply_reset();
    step(1, 0, 1, 0, '0);
    repeat (3) step(1, 0, 1, 0, '0);
    step(0, 0, 1, 1, 64'h8000_0100);
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 64'h8000_0100) begin
      n_fail++; $display("FAIL redirect_addr got req=%b addr=%h want 0 80000100", mem_req, mem_addr);
    end
    repeat (14) step(1, 1, 1, 0, '0);
  endtask

  task automatic test_collide();
    apply_reset();
    repeat (3) step(1, 0, 1, 0, '0);
    step(1, 1, 1, 1, 64'h8000_0200);
    repeat (12) step(1, 1, 1, 0, '0);
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (6) step(0, 0, 1, 0, '0);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== RPC) begin
      n_fail++; $display("FAIL stall_hold got req=%b addr=%h want 1 %h", mem_req, mem_addr, RPC);
    end
    step(0, 0, 1, 1, 64'h8000_0400);
    step(0, 0, 1, 0, '0);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0400) begin
      n_fail++; $display("FAIL stall_redirect got req=%b addr=%h want 1 80000400", mem_req, mem_addr);
    end
    repeat (8) step(1, 1, 1, 0, '0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (10) step(1, 1, 0, 0, '0);
    n_checks++;
    if (inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_before_reset got v=%b want 1", inst_valid);
    end
    #2 rst = 1'b1;
    mem_gnt = 0; mem_rvalid = 0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== RPC) begin
      n_fail++; $display("FAIL async_reset got v=%b req=%b addr=%h", inst_valid, mem_req, mem_addr);
    end
    @(negedge clk);
    apply_reset();
    repeat (10) step(1, 1, 1, 0, '0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bit redir;
      logic [63:0] rpc;
      redir = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      else rpc = {$urandom(), $urandom()} & ~64'h3;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) < 7, redir, rpc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_collide();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
